// File: rtl/sort_arbiter.sv
// sort_arbiter
//   Round-robin scheduler that shares one insertion-sort engine between two
//   AXI-Stream requesters. A whole job (pBLOCK_LEN words in, pBLOCK_LEN
//   sorted words out) is granted to one requester at a time:
//     IDLE -> GRANT (engine ap_start pulse) -> LOAD (s_x -> engine)
//          -> DRAIN (engine -> m_x) -> IDLE
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req0/req1                      level job requests
//   gnt0/gnt1                      high for the whole granted job
//   s{0,1}_tvalid/tdata/tlast/tready   requester input streams
//   m{0,1}_tvalid/tdata/tlast/tready   sorted output streams to requesters
//   eng_ap_start                   one-cycle engine start pulse
//   eng_ss_*                       engine input stream
//   eng_sm_tvalid/tdata/tready     engine output stream
//   busy                           state != IDLE
//   proto_err                      sticky input tlast position mismatch
//
// Optional feature (macro SORT_ARB_STATS_EN): adds 16-bit wrapping
// per-requester completed-job counters job_cnt0/job_cnt1.
module sort_arbiter #(
    parameter int pDATA_WIDTH = 32,
    parameter int pBLOCK_LEN  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   req1,
    output logic                   gnt0,
    output logic                   gnt1,
    input  logic                   s0_tvalid,
    input  logic [pDATA_WIDTH-1:0] s0_tdata,
    input  logic                   s0_tlast,
    output logic                   s0_tready,
    input  logic                   s1_tvalid,
    input  logic [pDATA_WIDTH-1:0] s1_tdata,
    input  logic                   s1_tlast,
    output logic                   s1_tready,
    output logic                   m0_tvalid,
    output logic [pDATA_WIDTH-1:0] m0_tdata,
    output logic                   m0_tlast,
    input  logic                   m0_tready,
    output logic                   m1_tvalid,
    output logic [pDATA_WIDTH-1:0] m1_tdata,
    output logic                   m1_tlast,
    input  logic                   m1_tready,
    output logic                   eng_ap_start,
    output logic                   eng_ss_tvalid,
    output logic [pDATA_WIDTH-1:0] eng_ss_tdata,
    output logic                   eng_ss_tlast,
    input  logic                   eng_ss_tready,
    input  logic                   eng_sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] eng_sm_tdata,
    output logic                   eng_sm_tready,
    output logic                   busy,
`ifdef SORT_ARB_STATS_EN
    output logic [15:0]            job_cnt0,
    output logic [15:0]            job_cnt1,
`endif
    output logic                   proto_err
);

    localparam int CW = $clog2(pBLOCK_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(pBLOCK_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_LOAD, ST_DRAIN} state_t;

    state_t          r_state, w_state_next;
    logic            r_sel, w_sel_next;
    logic            r_last_served;   // requester served by the previous job
    logic [CW-1:0]   r_cnt;
    logic            r_proto_err;
`ifdef SORT_ARB_STATS_EN
    logic [15:0]     r_job_cnt [2];
`endif

    // Per-requester views of the ports so both sides share one generate body.
    logic [1:0]             w_s_tvalid, w_s_tlast, w_m_tready;
    logic [pDATA_WIDTH-1:0] w_s_tdata [2];
    logic [1:0]             w_gnt, w_s_tready, w_m_tvalid, w_m_tlast;
    logic [pDATA_WIDTH-1:0] w_m_tdata [2];

    assign w_s_tvalid   = {s1_tvalid, s0_tvalid};
    assign w_s_tlast    = {s1_tlast, s0_tlast};
    assign w_m_tready   = {m1_tready, m0_tready};
    assign w_s_tdata[0] = s0_tdata;
    assign w_s_tdata[1] = s1_tdata;

    // Every output is forced low while rst is asserted, even mid-job before
    // the reset edge has returned the state register to IDLE.
    logic w_run, w_in_load, w_in_drain, w_ss_fire, w_sm_fire, w_cnt_at_last;
    assign w_run         = ~rst;
    assign w_in_load     = w_run && (r_state == ST_LOAD);
    assign w_in_drain    = w_run && (r_state == ST_DRAIN);
    assign w_cnt_at_last = (r_cnt == LAST_IDX);

    assign eng_ap_start  = w_run && (r_state == ST_GRANT);
    assign busy          = w_run && (r_state != ST_IDLE);
    assign proto_err     = w_run && r_proto_err;

    assign eng_ss_tvalid = w_in_load && w_s_tvalid[r_sel];
    assign eng_ss_tdata  = w_in_load ? w_s_tdata[r_sel] : '0;
    assign eng_ss_tlast  = w_in_load && w_s_tlast[r_sel];
    assign eng_sm_tready = w_in_drain && w_m_tready[r_sel];

    assign w_ss_fire = eng_ss_tvalid && eng_ss_tready;
    assign w_sm_fire = eng_sm_tvalid && eng_sm_tready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            logic w_own;
            assign w_own          = (r_sel == 1'(gi));
            assign w_gnt[gi]      = busy && w_own;
            assign w_s_tready[gi] = w_in_load && w_own && eng_ss_tready;
            assign w_m_tvalid[gi] = w_in_drain && w_own && eng_sm_tvalid;
            assign w_m_tdata[gi]  = (w_in_drain && w_own) ? eng_sm_tdata : '0;
            assign w_m_tlast[gi]  = w_in_drain && w_own && w_cnt_at_last;
        end
    endgenerate

    assign gnt0      = w_gnt[0];
    assign gnt1      = w_gnt[1];
    assign s0_tready = w_s_tready[0];
    assign s1_tready = w_s_tready[1];
    assign m0_tvalid = w_m_tvalid[0];
    assign m1_tvalid = w_m_tvalid[1];
    assign m0_tdata  = w_m_tdata[0];
    assign m1_tdata  = w_m_tdata[1];
    assign m0_tlast  = w_m_tlast[0];
    assign m1_tlast  = w_m_tlast[1];
`ifdef SORT_ARB_STATS_EN
    assign job_cnt0  = w_run ? r_job_cnt[0] : 16'd0;
    assign job_cnt1  = w_run ? r_job_cnt[1] : 16'd0;
`endif

    // Next-state logic. With both requests pending, the side not served
    // last wins; the reset value of r_last_served makes req0 win first.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_state_next = ST_GRANT;
                    w_sel_next   = (req0 && req1) ? ~r_last_served : req1;
                end
            end
            ST_GRANT: w_state_next = ST_LOAD;
            ST_LOAD: begin
                if (w_ss_fire && w_cnt_at_last) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_sm_fire && w_cnt_at_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= 1'b0;
            r_last_served <= 1'b1;
            r_cnt         <= '0;
            r_proto_err   <= 1'b0;
`ifdef SORT_ARB_STATS_EN
            r_job_cnt[0]  <= 16'd0;
            r_job_cnt[1]  <= 16'd0;
`endif
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            case (r_state)
                ST_GRANT: r_cnt <= '0;
                ST_LOAD: begin
                    if (w_ss_fire) begin
                        r_cnt <= w_cnt_at_last ? '0 : r_cnt + CW'(1);
                        // tlast must appear exactly on the final beat; the job
                        // still completes by count either way.
                        if (eng_ss_tlast != w_cnt_at_last) r_proto_err <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_sm_fire) begin
                        if (w_cnt_at_last) begin
                            r_cnt         <= '0;
                            r_last_served <= r_sel;
`ifdef SORT_ARB_STATS_EN
                            r_job_cnt[r_sel] <= r_job_cnt[r_sel] + 16'd1;
`endif
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_arbiter.sv
module tb_sort_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, gnt0, gnt1;
    logic        s0_tvalid, s0_tlast, s0_tready, s1_tvalid, s1_tlast, s1_tready;
    logic [31:0] s0_tdata, s1_tdata;
    logic        m0_tvalid, m0_tlast, m0_tready, m1_tvalid, m1_tlast, m1_tready;
    logic [31:0] m0_tdata, m1_tdata;
    logic        eng_ap_start, eng_ss_tvalid, eng_ss_tlast, eng_ss_tready;
    logic [31:0] eng_ss_tdata, eng_sm_tdata;
    logic        eng_sm_tvalid, eng_sm_tready, busy, proto_err;
`ifdef SORT_ARB_STATS_EN
    logic [15:0] job_cnt0, job_cnt1;
`endif

    always #5 clk = ~clk;

    sort_arbiter #(.pDATA_WIDTH(32), .pBLOCK_LEN(10)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .s0_tvalid(s0_tvalid), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tvalid(s1_tvalid), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m0_tvalid(m0_tvalid), .m0_tdata(m0_tdata), .m0_tlast(m0_tlast), .m0_tready(m0_tready),
        .m1_tvalid(m1_tvalid), .m1_tdata(m1_tdata), .m1_tlast(m1_tlast), .m1_tready(m1_tready),
        .eng_ap_start(eng_ap_start), .eng_ss_tvalid(eng_ss_tvalid), .eng_ss_tdata(eng_ss_tdata),
        .eng_ss_tlast(eng_ss_tlast), .eng_ss_tready(eng_ss_tready),
        .eng_sm_tvalid(eng_sm_tvalid), .eng_sm_tdata(eng_sm_tdata), .eng_sm_tready(eng_sm_tready),
        .busy(busy),
`ifdef SORT_ARB_STATS_EN
        .job_cnt0(job_cnt0), .job_cnt1(job_cnt1),
`endif
        .proto_err(proto_err)
    );

    // ---------------- behavioural sort engine (block of 10) ----------------
    logic [9:0][31:0] e_buf;
    int               e_phase, e_in, e_out;
    logic             e_stall;

    function automatic logic [31:0] kth(input logic [9:0][31:0] b, input int k);
        kth = '0;
        for (int i = 0; i < 10; i++) begin
            int r;
            r = 0;
            for (int j = 0; j < 10; j++)
                if (b[j] < b[i] || (b[j] == b[i] && j < i)) r++;
            if (r == k) kth = b[i];
        end
    endfunction

    assign eng_ss_tready = (e_phase == 1) && !e_stall;
    assign eng_sm_tvalid = (e_phase == 2);
    assign eng_sm_tdata  = (e_phase == 2) ? kth(e_buf, e_out) : 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            e_phase <= 0; e_in <= 0; e_out <= 0; e_stall <= 1'b0;
        end else begin
            case (e_phase)
                0: if (eng_ap_start) begin e_phase <= 1; e_in <= 0; e_stall <= 1'b0; end
                1: begin
                    e_stall <= ~e_stall;
                    if (eng_ss_tvalid && eng_ss_tready) begin
                        e_buf[e_in] <= eng_ss_tdata;
                        e_in <= e_in + 1;
                        if (e_in == 9) begin e_phase <= 2; e_out <= 0; end
                    end
                end
                default: if (eng_sm_tvalid && eng_sm_tready) begin
                    e_out <= e_out + 1;
                    if (e_out == 9) e_phase <= 0;
                end
            endcase
        end
    end

    int ap_cnt = 0;
    always @(posedge clk) if (eng_ap_start) ap_cnt <= ap_cnt + 1;

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;
    int leak   = 0;
    int tv [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_s(input int side, input logic v, input logic [31:0] d, input logic l);
        if (side == 0) begin s0_tvalid = v; s0_tdata = d; s0_tlast = l; end
        else           begin s1_tvalid = v; s1_tdata = d; s1_tlast = l; end
    endtask

    // Push nbeats of tv[] into requester side; tlast on beat tlast_beat (1-based).
    task automatic send(input int side, input int nbeats, input int tlast_beat, input int gap_pct);
        int idx = 0;
        int cyc = 0;
        while (idx < nbeats && cyc < 400) begin
            @(negedge clk);
            if ($urandom_range(99) < gap_pct) set_s(side, 1'b0, 32'd0, 1'b0);
            else set_s(side, 1'b1, tv[idx], (idx + 1) == tlast_beat);
            #1;
            if (side == 0 ? (s0_tvalid && s0_tready) : (s1_tvalid && s1_tready)) idx++;
            if (side == 0 ? s1_tready : s0_tready) leak++;
            cyc++;
        end
        check("send_beats", idx, nbeats);
    endtask

    // Collect 10 sorted beats; the inputs are permutations of 0..9.
    task automatic recv(input int side, input int ready_pct);
        int k = 0;
        int cyc = 0;
        while (k < 10 && cyc < 400) begin
            @(negedge clk);
            set_s(0, 1'b0, 32'd0, 1'b0);
            set_s(1, 1'b0, 32'd0, 1'b0);
            m0_tready = ($urandom_range(99) < ready_pct);
            m1_tready = ($urandom_range(99) < ready_pct);
            #1;
            if (side == 0 ? (m0_tvalid && m0_tready) : (m1_tvalid && m1_tready)) begin
                check($sformatf("m%0d_data[%0d]", side, k), side == 0 ? m0_tdata : m1_tdata, k);
                check($sformatf("m%0d_tlast[%0d]", side, k),
                      {31'd0, side == 0 ? m0_tlast : m1_tlast}, {31'd0, k == 9});
                k++;
            end
            if (side == 0 ? m1_tvalid : m0_tvalid) leak++;
            cyc++;
        end
        check("recv_beats", k, 10);
        $display("job side=%0d out_beats=%0d proto_err=%0b", side, k, proto_err);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ap_base;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        set_s(0, 1'b0, 32'd0, 1'b0); set_s(1, 1'b0, 32'd0, 1'b0);
        m0_tready = 1'b0; m1_tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt0", gnt0, 0);
        check("rst_busy", busy, 0);
        check("rst_ap_start", eng_ap_start, 0);
        check("rst_proto_err", proto_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // T1: req0 only, input pre-driven before grant
        tv = '{9, 3, 7, 1, 0, 8, 2, 6, 5, 4};
        ap_base = ap_cnt;
        leak = 0;
        req0 = 1'b1;
        set_s(0, 1'b1, 32'd9, 1'b0);
        @(negedge clk);
        check("t1_gnt0", gnt0, 1);
        check("t1_gnt1", gnt1, 0);
        check("t1_ap_start", eng_ap_start, 1);
        check("t1_grant_s0_tready", s0_tready, 0);
        check("t1_grant_ss_tvalid", eng_ss_tvalid, 0);
        req0 = 1'b0;
        send(0, 10, 10, 0);
        recv(0, 100);
        check("t1_ap_pulses", ap_cnt - ap_base, 1);
        check("t1_proto_err", proto_err, 0);
        check("t1_leak", leak, 0);
        @(negedge clk);
        check("t1_end_busy", busy, 0);
        check("t1_end_gnt0", gnt0, 0);

        // T2/T3: fresh reset, both requests held for four jobs
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tv = '{3, 8, 1, 9, 0, 6, 4, 2, 7, 5};
        leak = 0;
        req0 = 1'b1; req1 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin
                @(negedge clk);
                check($sformatf("t3_gap_busy_%0d", j), busy, 0);
            end
            @(negedge clk);
            check($sformatf("t3_gnt0_job%0d", j), gnt0, (j % 2) == 0);
            check($sformatf("t3_gnt1_job%0d", j), gnt1, (j % 2) == 1);
            send(j % 2, 10, 10, 0);
            recv(j % 2, 100);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        check("t3_end_busy", busy, 0);
        check("t3_leak", leak, 0);
        check("t3_proto_err", proto_err, 0);
`ifdef SORT_ARB_STATS_EN
        check("t3_job_cnt0", job_cnt0, 2);
        check("t3_job_cnt1", job_cnt1, 2);
`endif
        @(negedge clk);
        check("t3_stays_idle", busy, 0);

        // T4: random source gaps and sink back-pressure
        tv = '{5, 9, 0, 2, 8, 1, 7, 3, 6, 4};
        leak = 0;
        req0 = 1'b1;
        @(negedge clk);
        check("t4_gnt0", gnt0, 1);
        req0 = 1'b0;
        send(0, 10, 10, 50);
        recv(0, 50);
        check("t4_proto_err", proto_err, 0);
        check("t4_leak", leak, 0);
        @(negedge clk);

        // T5: early tlast sets sticky proto_err; job still completes
        tv = '{2, 7, 4, 0, 9, 1, 8, 6, 3, 5};
        req0 = 1'b1;
        @(negedge clk);
        check("t5_gnt0", gnt0, 1);
        req0 = 1'b0;
        send(0, 10, 5, 0);
        recv(0, 100);
        check("t5_proto_err", proto_err, 1);
        @(negedge clk);
        req1 = 1'b1;
        @(negedge clk);
        check("t5_gnt1", gnt1, 1);
        req1 = 1'b0;
        send(1, 10, 10, 0);
        recv(1, 100);
        check("t5_proto_err_sticky", proto_err, 1);
        @(negedge clk);

        // T6: reset during LOAD after four beats
        req0 = 1'b1;
        @(negedge clk);
        check("t6_gnt0", gnt0, 1);
        req0 = 1'b0;
        send(0, 4, 0, 0);
        @(negedge clk);
        set_s(0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rsthi_busy", busy, 0);
        check("t6_rsthi_s0_tready", s0_tready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_gnt0", gnt0, 0);
        check("t6_proto_err", proto_err, 0);
        tv = '{6, 0, 3, 9, 1, 5, 8, 2, 4, 7};
        req1 = 1'b1;
        @(negedge clk);
        check("t6_gnt1", gnt1, 1);
        req1 = 1'b0;
        send(1, 10, 10, 30);
        recv(1, 70);
        check("t6_proto_err_end", proto_err, 0);
        @(negedge clk);
        check("t6_end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
